// File: rtl/can_pkg.sv
// Shared types and constants for the CAN receive-to-DMA writer.
// Optional timestamp word is enabled with CAN_RX_DMA_TSTAMP_EN.
package can_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_NEXT
  } can_state_e;

  typedef enum logic [1:0] {
    W_DATA_1,
    W_DATA_2,
    W_TSTAMP,
    W_STATUS
  } can_word_e;

  localparam int STAT_VALID_BIT = 31;
  localparam int STAT_OVF_BIT   = 30;
  localparam int STAT_SEQ_LSB   = 24;
  localparam int STAT_SEQ_W     = 6;
  localparam int STAT_DLC_LSB   = 16;
  localparam int STAT_ADDR_LSB  = 0;

  localparam logic [19:0] CAN_ADDR_STATUS = 20'hA0010;
  localparam logic [19:0] CAN_ADDR_DATA_1 = 20'hA0011;
  localparam logic [19:0] CAN_ADDR_DATA_2 = 20'hA0012;
  localparam logic [19:0] CAN_ADDR_TSTAMP = 20'hA0013;

`ifdef CAN_RX_DMA_TSTAMP_EN
  localparam logic [2:0] CAN_TS_WORDS = 3'd1;
`else
  localparam logic [2:0] CAN_TS_WORDS = 3'd0;
`endif

  typedef struct packed {
`ifdef CAN_RX_DMA_TSTAMP_EN
    logic [31:0] tstamp;
`endif
    logic [63:0] data;
    logic [3:0]  dlc;
    logic [5:0]  addr;
  } can_entry_t;

  // DLC codes 9..15 behave as 8 for word selection only.
  function automatic logic [2:0] data_words(input logic [3:0] dlc);
    logic [3:0] eff;
    eff = (dlc > 4'd8) ? 4'd8 : dlc;
    if (eff == 4'd0)      return 3'd0;
    else if (eff <= 4'd4) return 3'd1;
    else                  return 3'd2;
  endfunction

  function automatic logic [2:0] word_count(input logic [3:0] dlc);
    return data_words(dlc) + CAN_TS_WORDS + 3'd1;
  endfunction

  function automatic can_word_e word_kind(input logic [3:0] dlc, input logic [2:0] idx);
    logic [2:0] nd;
    nd = data_words(dlc);
    if (idx < nd) return (idx == 3'd0) ? W_DATA_1 : W_DATA_2;
    if ((CAN_TS_WORDS != 3'd0) && (idx == nd)) return W_TSTAMP;
    return W_STATUS;
  endfunction

endpackage

// File: rtl/can_rx_fifo.sv
// Show-ahead frame FIFO; a push on a full FIFO is accepted when a pop
// happens in the same cycle.
module can_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/can_rx_dma_wr.sv
// Buffers received CAN frames and writes data/status words to fixed DMA
// addresses. Define CAN_RX_DMA_TSTAMP_EN to add a timestamp word.
module can_rx_dma_wr
  import can_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DATA_1 = ADDR_WIDTH'(CAN_ADDR_DATA_1),
  parameter logic [ADDR_WIDTH-1:0] ADDR_DATA_2 = ADDR_WIDTH'(CAN_ADDR_DATA_2),
  parameter logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(CAN_ADDR_STATUS),
  parameter logic [ADDR_WIDTH-1:0] ADDR_TSTAMP = ADDR_WIDTH'(CAN_ADDR_TSTAMP)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_frame_ready_i,
  input  logic [63:0]           rx_data_i,
  input  logic [3:0]            rx_dlc_i,
  input  logic [5:0]            rx_remote_addr_i,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic                  wr_en,
  input  logic                  wr_done,
  input  logic                  wr_busy,
  output logic                  busy_o,
  output logic [7:0]            frame_count_o,
  output logic [7:0]            drop_count_o
);

  localparam int ENTRY_W = $bits(can_entry_t);

  can_state_e            state_q, state_d;
  can_entry_t            work_q, work_d;
  can_entry_t            push_entry, head_entry;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_wr_q, data_wr_d;
  logic [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
  logic                  ovf_q, ovf_d;
  logic [5:0]            seq_q, seq_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic                  drop, status_done;
  can_word_e             load_kind, idx_kind;

  function automatic logic [31:0] word_data(input can_entry_t e, input can_word_e k,
                                            input logic ovf, input logic [5:0] seq);
    logic [31:0] w;
    w = '0;
    case (k)
      W_DATA_1: w = e.data[31:0];
      W_DATA_2: w = e.data[63:32];
`ifdef CAN_RX_DMA_TSTAMP_EN
      W_TSTAMP: w = e.tstamp;
`endif
      default: begin
        w[STAT_VALID_BIT]                 = 1'b1;
        w[STAT_OVF_BIT]                   = ovf;
        w[STAT_SEQ_LSB +: STAT_SEQ_W]     = seq;
        w[STAT_DLC_LSB +: 4]              = e.dlc;
        w[STAT_ADDR_LSB +: 6]             = e.addr;
      end
    endcase
    return w;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input can_word_e k);
    case (k)
      W_DATA_1: return ADDR_DATA_1;
      W_DATA_2: return ADDR_DATA_2;
      W_TSTAMP: return ADDR_TSTAMP;
      default:  return ADDR_STATUS;
    endcase
  endfunction

`ifdef CAN_RX_DMA_TSTAMP_EN
  logic [31:0] ts_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ts_cnt_q <= '0;
    else        ts_cnt_q <= ts_cnt_q + 32'd1;
  end
`endif

  always_comb begin
    push_entry        = '0;
    push_entry.data   = rx_data_i;
    push_entry.dlc    = rx_dlc_i;
    push_entry.addr   = rx_remote_addr_i;
`ifdef CAN_RX_DMA_TSTAMP_EN
    push_entry.tstamp = ts_cnt_q;
`endif
  end

  can_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_frame_ready_i),
    .pop_i   (fifo_pop),
    .din_i   (push_entry),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_entry = fifo_dout;
  assign fifo_pop   = (state_q == ST_LOAD);
  assign drop       = rx_frame_ready_i && fifo_full && !fifo_pop;
  assign load_kind  = word_kind(head_entry.dlc, 3'd0);
  assign idx_kind   = word_kind(work_q.dlc, idx_q);

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    idx_d       = idx_q;
    data_wr_d   = data_wr_q;
    addr_wr_d   = addr_wr_q;
    ovf_d       = ovf_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    status_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        work_d    = head_entry;
        idx_d     = 3'd0;
        data_wr_d = DATA_WIDTH'(word_data(head_entry, load_kind, ovf_q, seq_q));
        addr_wr_d = word_addr(load_kind);
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!wr_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (wr_done) begin
          idx_d       = idx_q + 3'd1;
          status_done = (idx_kind == W_STATUS);
          state_d     = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q < word_count(work_q.dlc)) begin
          data_wr_d = DATA_WIDTH'(word_data(work_q, idx_kind, ovf_q, seq_q));
          addr_wr_d = word_addr(idx_kind);
          state_d   = ST_ISSUE;
        end else begin
          data_wr_d = '0;
          addr_wr_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only clear the flag the completed status word actually reported, so a
    // drop landing while that word was in flight is not lost.
    if (status_done) begin
      seq_d       = seq_q + 6'd1;
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (data_wr_q[STAT_OVF_BIT]) ovf_d = 1'b0;
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      idx_q       <= '0;
      data_wr_q   <= '0;
      addr_wr_q   <= '0;
      ovf_q       <= 1'b0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      idx_q       <= idx_d;
      data_wr_q   <= data_wr_d;
      addr_wr_q   <= addr_wr_d;
      ovf_q       <= ovf_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign wr_en         = (state_q == ST_ISSUE) && !wr_busy;
  assign data_wr       = data_wr_q;
  assign addr_wr       = addr_wr_q;
  assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
  assign frame_count_o = frame_cnt_q;
  assign drop_count_o  = drop_cnt_q;

endmodule

// File: tb/tb_can_rx_dma_wr.sv
// Directed bench for can_rx_dma_wr with a small DMA responder model.
// Define CAN_RX_DMA_TSTAMP_EN to also cover the timestamp word.
module tb_can_rx_dma_wr;

`ifdef CAN_RX_DMA_TSTAMP_EN
  localparam int TSW = 1;
`else
  localparam int TSW = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_frame_ready_i = 1'b0;
  logic [63:0] rx_data_i = '0;
  logic [3:0]  rx_dlc_i = '0;
  logic [5:0]  rx_remote_addr_i = '0;
  logic [31:0] data_wr;
  logic [19:0] addr_wr;
  logic        wr_en;
  logic        wr_done = 1'b0;
  logic        wr_busy = 1'b0;
  logic        busy_o;
  logic [7:0]  frame_count_o;
  logic [7:0]  drop_count_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  logic        dma_hold = 1'b0;
  logic        done_pend = 1'b0;

  always #5 clk = ~clk;

  can_rx_dma_wr dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .rx_frame_ready_i (rx_frame_ready_i),
    .rx_data_i        (rx_data_i),
    .rx_dlc_i         (rx_dlc_i),
    .rx_remote_addr_i (rx_remote_addr_i),
    .data_wr          (data_wr),
    .addr_wr          (addr_wr),
    .wr_en            (wr_en),
    .wr_done          (wr_done),
    .wr_busy          (wr_busy),
    .busy_o           (busy_o),
    .frame_count_o    (frame_count_o),
    .drop_count_o     (drop_count_o)
  );

  // DMA model: logs each request and answers wr_done one cycle later unless held.
  always @(negedge clk) begin
    if (!rst_i) begin
      done_pend = 1'b0;
      wr_done   = 1'b0;
    end else begin
      wr_done = 1'b0;
      if (done_pend && !dma_hold) begin
        wr_done   = 1'b1;
        done_pend = 1'b0;
      end
      if (wr_en) begin
        wlog_a.push_back(addr_wr);
        wlog_d.push_back(data_wr);
        $display("[dma] t=%0t write addr=%h data=%h", $time, addr_wr, data_wr);
        done_pend = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[chk] %s ok (%0h)", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] d, input logic [3:0] dlc, input logic [5:0] a);
    rx_frame_ready_i = 1'b1;
    rx_data_i        = d;
    rx_dlc_i         = dlc;
    rx_remote_addr_i = a;
    cyc();
    rx_frame_ready_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 400) begin
      cyc();
      n++;
    end
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic expect_write(input string tag, input logic [19:0] a, input logic [31:0] d);
    logic [19:0] ga;
    logic [31:0] gd;
    chk({tag, "_present"}, (wlog_a.size() != 0), 1);
    if (wlog_a.size() != 0) begin
      ga = wlog_a.pop_front();
      gd = wlog_d.pop_front();
      chk({tag, "_addr"}, ga, a);
      chk({tag, "_data"}, gd, d);
    end
  endtask

  // Status is preceded by a timestamp write when that word is enabled.
  task automatic expect_status(input string tag, input logic [31:0] d);
`ifdef CAN_RX_DMA_TSTAMP_EN
    logic [19:0] ga;
    logic [31:0] gd;
    chk({tag, "_ts_present"}, (wlog_a.size() != 0), 1);
    if (wlog_a.size() != 0) begin
      ga = wlog_a.pop_front();
      gd = wlog_d.pop_front();
      chk({tag, "_ts_addr"}, ga, 20'hA0013);
    end
`endif
    expect_write(tag, 20'hA0010, d);
  endtask

  initial begin
    #2 rst_i = 1'b0;
    repeat (3) cyc();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_data_wr", data_wr, 0);
    chk("rst_addr_wr", addr_wr, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_frame_cnt", frame_count_o, 0);
    chk("rst_drop_cnt", drop_count_o, 0);
    rst_i = 1'b1;
    cyc();

    // dlc 8, seq 0
    send_frame(64'h1122334455667788, 4'd8, 6'h22);
    wait_idle("f8");
    expect_write("f8_d1", 20'hA0011, 32'h55667788);
    expect_write("f8_d2", 20'hA0012, 32'h11223344);
    expect_status("f8_st", 32'h8008_0022);
    chk("f8_frame_cnt", frame_count_o, 1);

    // dlc 0: status only, seq 1
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 6'h15);
    wait_idle("f0");
    chk("f0_nwrites", wlog_a.size(), 1 + TSW);
    expect_status("f0_st", 32'h8100_0015);

    // dlc 3: DATA_1 then status, seq 2
    send_frame(64'hCAFEBABE_DEADBEEF, 4'd3, 6'h3F);
    wait_idle("f3");
    chk("f3_nwrites", wlog_a.size(), 2 + TSW);
    expect_write("f3_d1", 20'hA0011, 32'hDEADBEEF);
    expect_status("f3_st", 32'h8203_003F);

    // dlc 15 clamps to 8 words but keeps raw dlc in status, seq 3
    send_frame(64'h01234567_89ABCDEF, 4'hF, 6'h01);
    wait_idle("f15");
    expect_write("f15_d1", 20'hA0011, 32'h89ABCDEF);
    expect_write("f15_d2", 20'hA0012, 32'h01234567);
    expect_status("f15_st", 32'h830F_0001);

    // wr_busy stall, seq 4
    wr_busy = 1'b1;
    send_frame(64'h0, 4'd0, 6'h05);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("busy_stall_%0d", i), wr_en, 0);
    end
    wr_busy = 1'b0;
    #1;
    chk("busy_release_wr_en", wr_en, 1);
    cyc();
    chk("busy_pulse_end", wr_en, 0);
    wait_idle("busy");
    chk("busy_nwrites", wlog_a.size(), 1 + TSW);
    expect_status("busy_st", 32'h8400_0005);

    // overflow: 6 frames with wr_done withheld, frames 1..5 get seq 5..9
    dma_hold = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      rx_frame_ready_i = 1'b1;
      rx_data_i        = {32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i)};
      rx_dlc_i         = 4'd8;
      rx_remote_addr_i = 6'(i);
      cyc();
    end
    rx_frame_ready_i = 1'b0;
    cyc();
    chk("ovf_drop_cnt", drop_count_o, 1);
    dma_hold = 1'b0;
    wait_idle("ovf");
    chk("ovf_nwrites", wlog_a.size(), 5 * (3 + TSW));
    expect_write("ovf1_d1", 20'hA0011, 32'hB000_0001);
    expect_write("ovf1_d2", 20'hA0012, 32'hA000_0001);
    expect_status("ovf1_st", 32'hC508_0001);
    expect_write("ovf2_d1", 20'hA0011, 32'hB000_0002);
    expect_write("ovf2_d2", 20'hA0012, 32'hA000_0002);
    expect_status("ovf2_st", 32'h8608_0002);
    wlog_a.delete();
    wlog_d.delete();
    chk("ovf_frame_cnt", frame_count_o, 10);

    // reset while waiting for wr_done
    dma_hold = 1'b1;
    send_frame(64'h0, 4'd0, 6'h2A);
    begin
      int n = 0;
      while (wlog_a.size() == 0 && n < 20) begin
        cyc();
        n++;
      end
    end
    chk("mid_rst_req_seen", (wlog_a.size() != 0), 1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_data_wr", data_wr, 0);
    chk("mid_rst_addr_wr", addr_wr, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_frame_cnt", frame_count_o, 0);
    chk("mid_rst_drop_cnt", drop_count_o, 0);
    cyc();
    rst_i    = 1'b1;
    dma_hold = 1'b0;
    wlog_a.delete();
    wlog_d.delete();
    cyc();
    send_frame(64'h0, 4'd0, 6'h11);
    wait_idle("post_rst");
    expect_status("post_rst_st", 32'h8000_0011);
    chk("post_rst_frame_cnt", frame_count_o, 1);

`ifdef CAN_RX_DMA_TSTAMP_EN
    // dlc 4 with timestamp: A0011, A0013, A0010; seq 1
    send_frame(64'h0000_0000_7777_6666, 4'd4, 6'h09);
    wait_idle("ts");
    chk("ts_nwrites", wlog_a.size(), 3);
    expect_write("ts_d1", 20'hA0011, 32'h7777_6666);
    expect_status("ts_st", 32'h8104_0009);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_rx_dma_wr.md
CAN_RX_DMA_WR -- requirements
Module: can_rx_dma_wr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, DMA data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 20, DMA address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of received frames buffered (power of 2).
REQ-004 SHALL have parameters ADDR_DATA_1 = 20'hA0011, ADDR_DATA_2 = 20'hA0012, ADDR_STATUS = 20'hA0010 and ADDR_TSTAMP = 20'hA0013, the destination addresses.
REQ-005 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_frame_ready_i, input, 1, one-cycle pulse meaning a received frame is valid.
REQ-008 SHALL have port rx_data_i, input, 64, frame payload; byte 0 is in [7:0].
REQ-009 SHALL have port rx_dlc_i, input, 4, data length code.
REQ-010 SHALL have port rx_remote_addr_i, input, 6, sender address.
REQ-011 SHALL have ports data_wr (output, DATA_WIDTH), addr_wr (output, ADDR_WIDTH) and wr_en (output, 1), forming the DMA write request.
REQ-012 SHALL have ports wr_done (input, 1, one-cycle completion pulse) and wr_busy (input, 1, DMA cannot accept a request).
REQ-013 SHALL have ports busy_o (output, 1), frame_count_o (output, 8) and drop_count_o (output, 8).

Function
REQ-014 SHALL capture {rx_data_i, rx_dlc_i, rx_remote_addr_i} into the frame FIFO on the cycle rx_frame_ready_i is high, provided the FIFO is not full.
REQ-015 SHALL, when rx_frame_ready_i arrives with the FIFO full and no pop in the same cycle, drop the frame, increment drop_count_o (saturating at 255) and set a sticky overflow flag.
REQ-016 SHALL accept the push when push and pop coincide on a full FIFO.
REQ-017 SHALL implement states IDLE, LOAD, ISSUE, WAIT_DONE and NEXT.
REQ-018 SHALL move IDLE->LOAD when the FIFO is non-empty, LOAD->ISSUE after popping the head entry into a working register, ISSUE->WAIT_DONE, WAIT_DONE->NEXT on wr_done, NEXT->ISSUE if words remain, and NEXT->IDLE otherwise.
REQ-019 SHALL hold wr_en high for exactly one cycle in ISSUE, and only when wr_busy is 0; ISSUE waits while wr_busy is 1.
REQ-020 SHALL keep data_wr and addr_wr stable from the wr_en cycle until wr_done.
REQ-021 SHALL clamp DLC values above 8 to 8 when selecting words, and write the raw DLC into the status word.
REQ-022 SHALL select words by effective DLC: 0 writes STATUS only; 1-4 writes DATA_1 then STATUS; 5-8 writes DATA_1, DATA_2, then STATUS.
REQ-023 SHALL write rx_data[31:0] to DATA_1 and rx_data[63:32] to DATA_2.
REQ-024 SHALL format the status word as: [31]=1, [30]=overflow flag, [29:24]=6-bit frame sequence, [19:16]=DLC, [5:0]=remote address, all other bits 0.
REQ-025 SHALL clear the overflow flag and increment frame_count_o (wrapping) and the sequence number (wrapping) in the cycle wr_done completes the STATUS write.
REQ-026 SHALL drive busy_o high whenever the state is not IDLE or the FIFO is non-empty.

Reset
REQ-027 SHALL, on rst_i low at any time (including mid-transfer), force wr_en=0, data_wr=0, addr_wr=0, busy_o=0, frame_count_o=0, drop_count_o=0, overflow=0, sequence=0, state IDLE, and an empty FIFO.

Configuration
REQ-028 SHALL, with CAN_RX_DMA_TSTAMP_EN defined, run a 32-bit free-running counter from reset, latch it at push into the FIFO entry, and write it to ADDR_TSTAMP immediately before STATUS.
REQ-029 SHALL, without CAN_RX_DMA_TSTAMP_EN, omit the counter and the TSTAMP write entirely.

Structure
REQ-030 SHALL place the state enum, status-word bit positions and default addresses in shared package can_pkg.
REQ-031 SHALL implement the frame FIFO as sub-module can_rx_fifo (width parameter, depth parameter, push/pop/full/empty).

Verification
REQ-032 SHALL verify: a frame with rx_data=64'h1122334455667788, dlc=8, addr=6'h22 produces the writes A0011<=55667788, A0012<=11223344, then A0010<=0x8008_0022.
REQ-033 SHALL verify: dlc=0 produces a single write, A0010<=0x8000_00xx, and dlc=3 produces a DATA_1 write then a STATUS write.
REQ-034 SHALL verify: wr_busy held high for 10 cycles leaves wr_en low throughout, then wr_en pulses exactly once.
REQ-035 SHALL verify: 6 back-to-back frames with wr_done withheld results in drop_count_o=1 (FIFO holds 4, 1 frame in the working register) and the next STATUS having bit 30 set.
REQ-036 SHALL verify: rst_i low during WAIT_DONE results in all outputs 0 the same cycle, and a new frame after reset is written with sequence 0.
REQ-037 SHALL verify, with CAN_RX_DMA_TSTAMP_EN defined: dlc=4 produces the write order A0011, A0013, A0010.
